// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Lane math assumes a 32-bit data path.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] be_of(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3[1:0])
            2'b00:   be_of = 4'b0001 << off;
            2'b01:   be_of = 4'b0011 << off;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] shift_wdata(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] wd
    );
        logic [31:0] m;
        case (f3[1:0])
            2'b00:   m = {24'b0, wd[7:0]};
            2'b01:   m = {16'b0, wd[15:0]};
            default: m = wd;
        endcase
        shift_wdata = m << {off, 3'b000};
    endfunction

    function automatic logic [31:0] extend(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] rd
    );
        logic [31:0] l;
        l = rd >> {off, 3'b000};
        case (f3)
            F3_B:    extend = {{24{l[7]}}, l[7:0]};
            F3_H:    extend = {{16{l[15]}}, l[15:0]};
            F3_BU:   extend = {24'b0, l[7:0]};
            F3_HU:   extend = {16'b0, l[15:0]};
            default: extend = l;
        endcase
    endfunction

    function automatic logic is_legal(
        input logic       store,
        input logic [2:0] f3
    );
        if (store)
            is_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            is_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store shift,
// load extract/extend and access legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic misaligned;

    // Half needs even offset, word needs offset zero.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned = off_i[0];
            2'b10:   misaligned = (off_i != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign be_o    = be_of(funct3_i, off_i);
    assign wdata_o = shift_wdata(funct3_i, off_i, wdata_i);
    assign rdata_o = extend(funct3_i, off_i, rdata_i);
    assign err_o   = misaligned | ~is_legal(store_i, funct3_i);

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access to a variable-latency
// memory with misalignment, illegal-op and timeout reporting.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [2:0]               req_funct3,
    input  logic [DATA_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [ADDRESS_WIDTH-1:0] req_rd,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [ADDRESS_WIDTH-1:0] resp_rd,
    output logic                     resp_we,
    output logic                     resp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     store_q, store_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               off_q, off_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;

    logic                     mreq_q, mreq_d;
    logic                     mwe_q, mwe_d;
    logic [DATA_WIDTH-1:0]    maddr_q, maddr_d;
    logic [3:0]               mbe_q, mbe_d;
    logic [DATA_WIDTH-1:0]    mwd_q, mwd_d;

    logic                     rv_q, rv_d;
    logic [DATA_WIDTH-1:0]    rdat_q, rdat_d;
    logic [ADDRESS_WIDTH-1:0] rrd_q, rrd_d;
    logic                     rwe_q, rwe_d;
    logic                     rerr_q, rerr_d;

    logic                     idle;
    logic                     a_store;
    logic [2:0]               a_f3;
    logic [1:0]               a_off;
    logic [3:0]               a_be;
    logic [31:0]              a_wd;
    logic [31:0]              a_rd;
    logic                     a_err;

    assign idle = (state_q == S_IDLE);

    // Live request fields while idle, captured fields afterwards.
    assign a_store = idle ? req_store     : store_q;
    assign a_f3    = idle ? req_funct3    : f3_q;
    assign a_off   = idle ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .store_i  (a_store),
        .funct3_i (a_f3),
        .off_i    (a_off),
        .wdata_i  (req_wdata),
        .rdata_i  (mem_rdata),
        .be_o     (a_be),
        .wdata_o  (a_wd),
        .rdata_o  (a_rd),
        .err_o    (a_err)
    );

    // Next-state and registered-output logic for the access FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        store_d = store_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        mreq_d  = mreq_q;
        mwe_d   = mwe_q;
        maddr_d = maddr_q;
        mbe_d   = mbe_q;
        mwd_d   = mwd_q;
        rv_d    = rv_q;
        rdat_d  = rdat_q;
        rrd_d   = rrd_q;
        rwe_d   = rwe_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    rd_d    = req_rd;
                    if (a_err) begin
                        state_d = S_RESP;
                        rv_d    = 1'b1;
                        rerr_d  = 1'b1;
                        rwe_d   = 1'b0;
                        rdat_d  = '0;
                        rrd_d   = req_store ? '0 : req_rd;
                    end else begin
                        state_d = S_ISSUE;
                        mreq_d  = 1'b1;
                        mwe_d   = req_store;
                        maddr_d = {req_addr[DATA_WIDTH-1:2], 2'b00};
                        mbe_d   = a_be;
                        mwd_d   = req_store ? a_wd : '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                mreq_d  = 1'b0;
                mwe_d   = 1'b0;
                maddr_d = '0;
                mbe_d   = '0;
                mwd_d   = '0;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_RESP;
                    rv_d    = 1'b1;
                    rerr_d  = 1'b0;
                    rwe_d   = ~store_q;
                    rdat_d  = store_q ? '0 : a_rd;
                    rrd_d   = store_q ? '0 : rd_q;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = S_RESP;
                    rv_d    = 1'b1;
                    rerr_d  = 1'b1;
                    rwe_d   = 1'b0;
                    rdat_d  = '0;
                    rrd_d   = store_q ? '0 : rd_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rv_d    = 1'b0;
                    rdat_d  = '0;
                    rrd_d   = '0;
                    rwe_d   = 1'b0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            maddr_q <= '0;
            mbe_q   <= '0;
            mwd_q   <= '0;
            rv_q    <= 1'b0;
            rdat_q  <= '0;
            rrd_q   <= '0;
            rwe_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
            maddr_q <= maddr_d;
            mbe_q   <= mbe_d;
            mwd_q   <= mwd_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
            rrd_q   <= rrd_d;
            rwe_q   <= rwe_d;
            rerr_q  <= rerr_d;
        end
    end

    assign req_ready  = idle;
    assign mem_req    = mreq_q;
    assign mem_we     = mwe_q;
    assign mem_addr   = maddr_q;
    assign mem_be     = mbe_q;
    assign mem_wdata  = mwd_q;
    assign resp_valid = rv_q;
    assign resp_data  = rdat_q;
    assign resp_rd    = rrd_q;
    assign resp_we    = rwe_q;
    assign resp_err   = rerr_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table, directed corner
// sequences and random accesses against a size/offset model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_we;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_we    (resp_we),
        .resp_err   (resp_err)
    );

    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] rdat;
        bit        e_err;
        bit [3:0]  e_be;
        bit [31:0] e_wd;
        bit [31:0] e_data;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic chk_quiet(input string n);
        chk({n, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({n, ".mem_req"}, 32'(mem_req), 32'd0);
        chk({n, ".mem_we"}, 32'(mem_we), 32'd0);
        chk({n, ".mem_addr"}, mem_addr, 32'd0);
        chk({n, ".mem_be"}, 32'(mem_be), 32'd0);
        chk({n, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({n, ".resp_valid"}, 32'(resp_valid), 32'd0);
        chk({n, ".resp_data"}, resp_data, 32'd0);
        chk({n, ".resp_rd"}, 32'(resp_rd), 32'd0);
        chk({n, ".resp_we"}, 32'(resp_we), 32'd0);
        chk({n, ".resp_err"}, 32'(resp_err), 32'd0);
    endtask

    // Reference: access described by size in bytes and signedness.
    task automatic model(input bit st, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] wd,
                         input bit [31:0] rdat, output bit err,
                         output bit [3:0] be, output bit [31:0] mwd,
                         output bit [31:0] data);
        int size;
        bit sgn;
        bit legal;
        int off;
        longint v;
        longint span;
        off  = int'(a % 4);
        size = 0;
        sgn  = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: size = 0;
        endcase
        legal = (size != 0) && !(st && f3 > 3'd2);
        err = !legal || (off % size != 0);
        be = 0;
        mwd = 0;
        data = 0;
        if (!err) begin
            for (int i = 0; i < size; i++) be[off + i] = 1'b1;
            span = longint'(1) << (8 * size);
            v = longint'(wd) % span;
            mwd = 32'(v << (8 * off));
            v = (longint'(rdat) >> (8 * off)) % span;
            if (sgn && v >= span / 2) v = v - span;
            data = 32'(v);
        end
    endtask

    task automatic run_txn(input bit st, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] wd,
                           input bit [31:0] rdat, input bit [4:0] rd,
                           input int lat, input int hold,
                           input bit e_err, input bit [3:0] e_be,
                           input bit [31:0] e_wd, input bit [31:0] e_data);
        bit stable;
        bit [31:0] snap;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        chk("accept.req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (e_err) begin
            chk("err.mem_req", 32'(mem_req), 32'd0);
            chk("err.resp_valid", 32'(resp_valid), 32'd1);
            chk("err.resp_err", 32'(resp_err), 32'd1);
            chk("err.resp_we", 32'(resp_we), 32'd0);
            chk("err.resp_data", resp_data, 32'd0);
        end else begin
            chk("issue.mem_req", 32'(mem_req), 32'd1);
            chk("issue.mem_we", 32'(mem_we), 32'(st));
            chk("issue.mem_addr", mem_addr, a & ~32'h3);
            chk("issue.mem_be", 32'(mem_be), 32'(e_be));
            if (st) chk("issue.mem_wdata", mem_wdata, e_wd);
            // A strobe during the issue cycle must be ignored.
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            chk("wait.mem_req", 32'(mem_req), 32'd0);
            chk("wait.resp_valid", 32'(resp_valid), 32'd0);
            repeat (lat) @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = rdat;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            chk("resp.valid", 32'(resp_valid), 32'd1);
            chk("resp.err", 32'(resp_err), 32'd0);
            chk("resp.we", 32'(resp_we), 32'(!st));
            chk("resp.data", resp_data, st ? 32'd0 : e_data);
            chk("resp.rd", 32'(resp_rd), st ? 32'd0 : 32'(rd));
        end
        stable = 1'b1;
        snap = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!resp_valid || req_ready || resp_data !== snap)
                stable = 1'b0;
        end
        if (hold > 0) chk("hold.stable", 32'(stable), 32'd1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("done.resp_valid", 32'(resp_valid), 32'd0);
        chk("done.req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic run_model(input bit st, input bit [2:0] f3,
                             input bit [31:0] a, input bit [31:0] wd,
                             input bit [31:0] rdat, input bit [4:0] rd,
                             input int lat, input int hold);
        bit e;
        bit [3:0] be;
        bit [31:0] mwd;
        bit [31:0] dat;
        model(st, f3, a, wd, rdat, e, be, mwd, dat);
        run_txn(st, f3, a, wd, rdat, rd, lat, hold, e, be, mwd, dat);
    endtask

    vec_t vt[12];

    initial begin
        bit flag;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        resp_ready = 1'b0;

        vt[0]  = '{1, 3'd0, 32'h103, 32'hAB, 0, 0, 4'h8, 32'hAB000000, 0};
        vt[1]  = '{0, 3'd0, 32'h102, 0, 32'h00F00000, 0, 4'h4, 0, 32'hFFFFFFF0};
        vt[2]  = '{0, 3'd4, 32'h102, 0, 32'h00F00000, 0, 4'h4, 0, 32'h000000F0};
        vt[3]  = '{0, 3'd1, 32'h101, 0, 0, 1, 0, 0, 0};
        vt[4]  = '{0, 3'd1, 32'h102, 0, 32'h80010000, 0, 4'hC, 0, 32'hFFFF8001};
        vt[5]  = '{0, 3'd5, 32'h102, 0, 32'h80010000, 0, 4'hC, 0, 32'h00008001};
        vt[6]  = '{1, 3'd1, 32'h102, 32'h1234ABCD, 0, 0, 4'hC, 32'hABCD0000, 0};
        vt[7]  = '{1, 3'd2, 32'h200, 32'hDEADBEEF, 0, 0, 4'hF, 32'hDEADBEEF, 0};
        vt[8]  = '{0, 3'd2, 32'h204, 0, 32'h12345678, 0, 4'hF, 0, 32'h12345678};
        vt[9]  = '{0, 3'd2, 32'h206, 0, 0, 1, 0, 0, 0};
        vt[10] = '{0, 3'd3, 32'h208, 0, 0, 1, 0, 0, 0};
        vt[11] = '{1, 3'd4, 32'h208, 32'h77, 0, 1, 0, 0, 0};

        #12;
        chk_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_txn(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd,
                    vt[i].rdat, 5'(i + 1), i % 3, 0, vt[i].e_err,
                    vt[i].e_be, vt[i].e_wd, vt[i].e_data);

        // Backpressure: five cycles of resp_ready low.
        run_txn(0, 3'd2, 32'h300, 0, 32'h55AA55AA, 5'd9, 0, 5,
                0, 4'hF, 0, 32'h55AA55AA);
        run_txn(0, 3'd0, 32'h301, 0, 32'h00007F00, 5'd3, 0, 0,
                0, 4'h2, 0, 32'h0000007F);

        // Timeout: no ack, error exactly 16 cycles into WAIT.
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h400;
        req_rd     = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("to.mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        flag = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            if (resp_valid) flag = 1'b0;
        end
        chk("to.early_resp", 32'(flag), 32'd1);
        @(posedge clk); #1;
        chk("to.resp_valid", 32'(resp_valid), 32'd1);
        chk("to.resp_err", 32'(resp_err), 32'd1);
        chk("to.resp_we", 32'(resp_we), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        repeat (2) @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("to.late_err", 32'(resp_err), 32'd1);
        chk("to.late_data", resp_data, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        mem_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("to.idle_rvalid", 32'(resp_valid), 32'd0);
        chk("to.idle_ready", 32'(req_ready), 32'd1);

        // Reset while waiting for memory.
        req_valid  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h500;
        req_rd     = 5'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h22222222;
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid || mem_req) flag = 1'b0;
        end
        mem_rvalid = 1'b0;
        chk("midrst.no_resp", 32'(flag), 32'd1);

        for (int i = 0; i < 40; i++) begin
            bit        st;
            bit [2:0]  f3;
            bit [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            run_model(st, f3, a, $urandom, $urandom,
                      5'($urandom_range(0, 31)),
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
